fp_addsub_pipe: RTL and testbench

- Parametrised, 3-stage pipelined floating-point adder/subtractor; default format is bfloat16 (1 sign, 8 exponent, 7 mantissa).
- Adds round-to-nearest-even, IEEE special-value handling, an add/sub mode bit and valid/ready handshaking on both sides.
- Sits between the operand issue logic and the FPU result writeback.

---
 rtl/fp_addsub_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor (bfloat16 by default) with RNE rounding,
// flush-to-zero, IEEE special values and a single global stall driven by out_ready.
module fp_addsub_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned XW  = MAN_W + 4;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned MW2 = MAN_W + 2;
  localparam int unsigned LZW = $clog2(XW + 1);
  localparam logic [W-1:0]  QNAN    = W'({(EXP_W + 1){1'b1}}) << (MAN_W - 1);
  localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [XW-1:0]    m_big;
    logic [XW-1:0]    m_small;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [XW:0]      sum;
  } s2_t;

  typedef struct packed {
    logic          spec;
    logic [W-1:0]  spec_res;
    logic          sign;
    logic          zero;
    logic [EW-1:0] exp;
    logic [XW-1:0] norm;
  } s3_t;

  logic advance;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic out_valid_q, out_valid_d;
  s1_t  s1_q, s1_d, s1_new;
  s2_t  s2_q, s2_d, s2_new;
  s3_t  s3_q, s3_d, s3_new;
  logic [W-1:0] result_q, result_d, res_new;
  logic ovf_q, ovf_d, ovf_new, unf_q, unf_d, unf_new, inx_q, inx_d, inx_new;

  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
  logic [EXP_W-1:0] ea, eb, big_e, sm_e, diff, shamt;
  logic [MAN_W-1:0] ma, mb, big_m, sm_m;
  logic [2*XW-1:0]  wide;
  logic [LZW-1:0]   lz;
  logic [MAN_W:0]   mant;
  logic [MW2-1:0]   mant_r;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0]    e_r;
  logic             g, r, st, rnd_up;

  // S1: unpack, specials/zero bypass, magnitude swap and sticky alignment
  always_comb begin
    sa     = op_a[W-1];
    ea     = op_a[W-2:MAN_W];
    ma     = op_a[MAN_W-1:0];
    sb     = op_b[W-1] ^ sub;
    eb     = op_b[W-2:MAN_W];
    mb     = op_b[MAN_W-1:0];
    a_nan  = (&ea) & (|ma);
    b_nan  = (&eb) & (|mb);
    a_inf  = (&ea) & ~(|ma);
    b_inf  = (&eb) & ~(|mb);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    a_ge   = {ea, ma} >= {eb, mb};
    big_e  = a_ge ? ea : eb;
    sm_e   = a_ge ? eb : ea;
    big_m  = a_ge ? ma : mb;
    sm_m   = a_ge ? mb : ma;
    diff   = big_e - sm_e;
    shamt  = (diff >= EXP_W'(XW)) ? EXP_W'(XW) : diff;
    wide   = {1'b1, sm_m, 3'b000, XW'(0)} >> shamt;

    s1_new          = '0;
    s1_new.sign     = a_ge ? sa : sb;
    s1_new.eff_sub  = sa ^ sb;
    s1_new.exp      = big_e;
    s1_new.m_big    = {1'b1, big_m, 3'b000};
    s1_new.m_small  = wide[2*XW-1:XW] | XW'(|wide[XW-1:0]);
    s1_new.spec     = 1'b1;
    if (a_nan || b_nan)                s1_new.spec_res = QNAN;
    else if (a_inf && b_inf && sa != sb) s1_new.spec_res = QNAN;
    else if (a_inf)                    s1_new.spec_res = op_a;
    else if (b_inf)                    s1_new.spec_res = {sb, eb, mb};
    else if (a_zero && b_zero)         s1_new.spec_res = {sa & sb, (W - 1)'(0)};
    else if (b_zero)                   s1_new.spec_res = op_a;
    else if (a_zero)                   s1_new.spec_res = {sb, eb, mb};
    else                               s1_new.spec = 1'b0;
  end

  // S2: extended mantissa add/subtract; the larger operand is always first
  always_comb begin
    s2_new          = '0;
    s2_new.spec     = s1_q.spec;
    s2_new.spec_res = s1_q.spec_res;
    s2_new.sign     = s1_q.sign;
    s2_new.exp      = s1_q.exp;
    s2_new.sum      = s1_q.eff_sub ? ({1'b0, s1_q.m_big} - {1'b0, s1_q.m_small})
                                   : ({1'b0, s1_q.m_big} + {1'b0, s1_q.m_small});
  end

  // S3a: normalise; a carry shifts right folding the dropped bit into sticky
  always_comb begin
    lz = LZW'(XW);
    for (int i = 0; i < XW; i++) begin
      if (s2_q.sum[i]) lz = LZW'(XW - 1 - i);
    end
    s3_new          = '0;
    s3_new.spec     = s2_q.spec;
    s3_new.spec_res = s2_q.spec_res;
    s3_new.sign     = s2_q.sign;
    s3_new.zero     = ~(|s2_q.sum);
    if (s2_q.sum[XW]) begin
      s3_new.norm = {s2_q.sum[XW:2], |s2_q.sum[1:0]};
      s3_new.exp  = EW'(s2_q.exp) + EW'(1);
    end else begin
      s3_new.norm = s2_q.sum[XW-1:0] << lz;
      s3_new.exp  = EW'(s2_q.exp) - EW'(lz);
    end
  end

  // S3b: round to nearest even, range checks and flags
  always_comb begin
    mant    = s3_q.norm[XW-1:3];
    g       = s3_q.norm[2];
    r       = s3_q.norm[1];
    st      = s3_q.norm[0];
    rnd_up  = g & (r | st | mant[0]);
    mant_r  = {1'b0, mant} + MW2'(rnd_up);
    e_r     = s3_q.exp + EW'(mant_r[MAN_W+1]);
    frac    = mant_r[MAN_W+1] ? '0 : mant_r[MAN_W-1:0];
    res_new = '0;
    ovf_new = 1'b0;
    unf_new = 1'b0;
    inx_new = 1'b0;
    if (s3_q.spec) begin
      res_new = s3_q.spec_res;
    end else if (s3_q.zero) begin
      res_new = '0;
    end else if (s3_q.exp[EW-1] || s3_q.exp == '0) begin
      res_new = {s3_q.sign, (W - 1)'(0)};
      unf_new = 1'b1;
      inx_new = 1'b1;
    end else if (e_r >= EXP_MAX) begin
      res_new = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_new = 1'b1;
      inx_new = 1'b1;
    end else begin
      res_new = {s3_q.sign, e_r[EXP_W-1:0], frac};
      inx_new = g | r | st;
    end
  end

  // Global stall: every rank moves together or holds together
  always_comb begin
    advance     = ~out_valid_q | out_ready;
    s1_valid_d  = s1_valid_q;
    s2_valid_d  = s2_valid_q;
    s3_valid_d  = s3_valid_q;
    out_valid_d = out_valid_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    if (advance) begin
      s1_valid_d  = in_valid;
      s2_valid_d  = s1_valid_q;
      s3_valid_d  = s2_valid_q;
      out_valid_d = s3_valid_q;
      s1_d        = s1_new;
      s2_d        = s2_new;
      s3_d        = s3_new;
      result_d    = s3_valid_q ? res_new : '0;
      ovf_d       = s3_valid_q & ovf_new;
      unf_d       = s3_valid_q & unf_new;
      inx_d       = s3_valid_q & inx_new;
    end
    in_ready  = advance;
    out_valid = out_valid_q;
    result    = result_q;
    overflow  = ovf_q;
    underflow = unf_q;
    inexact   = inx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
    end
  end

  // Payload ranks carry no reset; their valid bits qualify them
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (bfloat16): arithmetic vectors,
// latency, stall behaviour, ordering and mid-flight reset.
module tb_fp_addsub_pipe;
  localparam int unsigned W  = 16;
  localparam int unsigned NV = 18;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, sub, out_valid, out_ready;
  logic [W-1:0] op_a, op_b, result;
  logic         overflow, underflow, inexact;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] va [NV];
  logic [W-1:0] vb [NV];
  logic         vs [NV];
  logic [W+2:0] vexp [NV];

  fp_addsub_pipe #(.EXP_W(8), .MAN_W(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .overflow(overflow),
    .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic set_vec(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] res, input logic [2:0] fl);
    va[i] = a; vb[i] = b; vs[i] = s; vexp[i] = {res, fl};
  endtask

  // flags field order: {overflow, underflow, inexact}
  task automatic init_vectors;
    set_vec(0,  16'h3F80, 16'h3F80, 1'b0, 16'h4000, 3'b000);
    set_vec(1,  16'h4000, 16'h3F80, 1'b1, 16'h3F80, 3'b000);
    set_vec(2,  16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 3'b001);
    set_vec(3,  16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 3'b001);
    set_vec(4,  16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 3'b101);
    set_vec(5,  16'h3F80, 16'h3F80, 1'b1, 16'h0000, 3'b000);
    set_vec(6,  16'h0080, 16'h0081, 1'b1, 16'h8000, 3'b011);
    set_vec(7,  16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 3'b000);
    set_vec(8,  16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 3'b000);
    set_vec(9,  16'hFF80, 16'h4000, 1'b0, 16'hFF80, 3'b000);
    set_vec(10, 16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000);
    set_vec(11, 16'h8000, 16'h0000, 1'b0, 16'h0000, 3'b000);
    set_vec(12, 16'h4040, 16'h0000, 1'b1, 16'h4040, 3'b000);
    set_vec(13, 16'h0001, 16'h3F80, 1'b0, 16'h3F80, 3'b000);
    set_vec(14, 16'h4B80, 16'h3F80, 1'b0, 16'h4B80, 3'b001);
    set_vec(15, 16'h3F80, 16'h3B80, 1'b1, 16'h3F7F, 3'b000);
    set_vec(16, 16'h3F80, 16'hBF00, 1'b0, 16'h3F00, 3'b000);
    set_vec(17, 16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 3'b000);
  endtask

  // Issue one op into an idle pipe; lat = edges from acceptance to out_valid
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W+2:0] obs, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    obs = {result, overflow, underflow, inexact};
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else passed++;
    checks++;
    if ({result, overflow, underflow, inexact} !== 19'h0)
      $display("FAIL reset_result_flags: got %h/%b%b%b expected 0000/000",
               result, overflow, underflow, inexact);
    else passed++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_vectors;
    logic [W+2:0] obs;
    int lat;
    for (int i = 0; i < NV; i++) begin
      run_op(va[i], vb[i], vs[i], obs, lat);
      checks++;
      if (obs !== vexp[i])
        $display("FAIL vec%0d_result: %h op %h sub=%b got %h/%b expected %h/%b",
                 i, va[i], vb[i], vs[i], obs[W+2:3], obs[2:0], vexp[i][W+2:3], vexp[i][2:0]);
      else passed++;
      checks++;
      if (lat != 3) $display("FAIL vec%0d_latency: got %0d expected 3", i, lat);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int rcvd = 0;
    int dups = 0;
    logic [W+2:0] held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (sent < 8);
      if (!out_ready) begin
        op_a = 16'h1234; op_b = 16'h5678; sub = 1'b0;
      end else if (sent < 8) begin
        op_a = va[sent]; op_b = vb[sent]; sub = vs[sent];
      end
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc%0d: got %b expected 0", cyc, in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL stall_out_valid cyc%0d: got %b expected 1", cyc, out_valid);
        else passed++;
        if (cyc == 6) held = {result, overflow, underflow, inexact};
        else begin
          checks++;
          if ({result, overflow, underflow, inexact} !== held)
            $display("FAIL stall_stable cyc%0d: got %h expected %h", cyc,
                     {result, overflow, underflow, inexact}, held);
          else passed++;
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if ({result, overflow, underflow, inexact} !== vexp[rcvd])
          $display("FAIL stream_out%0d: got %h/%b%b%b expected %h/%b", rcvd, result,
                   overflow, underflow, inexact, vexp[rcvd][W+2:3], vexp[rcvd][2:0]);
        else passed++;
        rcvd++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rcvd != 8 || sent != 8) $display("FAIL stream_count: got rcvd=%0d sent=%0d expected 8/8", rcvd, sent);
    else passed++;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) dups++;
    end
    checks++;
    if (dups != 0) $display("FAIL stream_extra_out: got %0d extra valid cycles expected 0", dups);
    else passed++;
  endtask

  task automatic test_reset_flush;
    logic [W+2:0] obs;
    int lat;
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op_a = va[i]; op_b = vb[i]; sub = vs[i];
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || result !== '0)
      $display("FAIL flush_after_reset: got valid=%b result=%h expected 0/0000", out_valid, result);
    else passed++;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) $display("FAIL flush_stale: got %0d valid cycles expected 0", stale);
    else passed++;
    run_op(va[15], vb[15], vs[15], obs, lat);
    checks++;
    if (obs !== vexp[15]) $display("FAIL post_reset_result: got %h expected %h", obs, vexp[15]);
    else passed++;
    checks++;
    if (lat != 3) $display("FAIL post_reset_latency: got %0d expected 3", lat);
    else passed++;
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
